// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: a six-state F/D/E/M/W/H sequencer with a registered
// decode of the instruction opcode/func and a bounded data-memory wait.
module multicycle_control_unit #(
  parameter int                 OPC_W       = 6,
  parameter int                 FUNC_W      = 5,
  parameter int                 ALUOP_W     = 5,
  parameter logic [OPC_W-1:0]   HALT_OPC    = '1,
  parameter int                 MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNC_W-1:0]  func,
  input  logic               instr_valid,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_sel,
  output logic               is_branch,
  output logic               branch_addr_sel,
  output logic               lbl_sel,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               mem_err,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LW, K_SW, K_BR, K_BL, K_ILL
  } kind_t;

  typedef struct packed {
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_sel;
    logic               is_branch;
    logic               branch_addr_sel;
    logic               lbl_sel;
  } ctl_t;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state_q;
  kind_t            kind_q;
  kind_t            dec_kind;
  ctl_t             ctl_q;
  ctl_t             dec_ctl;
  logic [CNT_W-1:0] wait_cnt;

  // Combinational decode of the current IR; only sampled into ctl_q in D.
  always_comb begin
    dec_ctl  = '0;
    dec_kind = K_ILL;
    case (opcode)
      OPC_W'(0): begin
        dec_ctl.mem_to_reg = 2'b10;
        if (func == FUNC_W'(0)) begin
          dec_kind       = K_ALU;
          dec_ctl.alu_op = ALUOP_W'(5'b00001);
        end else if (func == FUNC_W'(1)) begin
          dec_kind        = K_ALU;
          dec_ctl.alu_op  = ALUOP_W'(5'b00101);
          dec_ctl.alu_sel = 1'b1;
        end
      end
      OPC_W'(1): begin
        dec_ctl.mem_to_reg = 2'b10;
        if (func == FUNC_W'(0)) begin
          dec_kind       = K_ALU;
          dec_ctl.alu_op = ALUOP_W'(5'b00010);
        end else if (func == FUNC_W'(1)) begin
          dec_kind       = K_ALU;
          dec_ctl.alu_op = ALUOP_W'(5'b00011);
        end
      end
      OPC_W'(2): begin
        // Even funcs 0/4 and func 1 take the shift amount from the immediate.
        dec_ctl.mem_to_reg = 2'b10;
        case (func)
          FUNC_W'(0): begin dec_kind = K_ALU; dec_ctl.alu_src = 1'b1; dec_ctl.alu_op = ALUOP_W'(5'b01010); end
          FUNC_W'(1): begin dec_kind = K_ALU; dec_ctl.alu_src = 1'b1; dec_ctl.alu_op = ALUOP_W'(5'b01000); end
          FUNC_W'(2): begin dec_kind = K_ALU; dec_ctl.alu_op = ALUOP_W'(5'b01010); end
          FUNC_W'(3): begin dec_kind = K_ALU; dec_ctl.alu_op = ALUOP_W'(5'b01000); end
          FUNC_W'(4): begin dec_kind = K_ALU; dec_ctl.alu_src = 1'b1; dec_ctl.alu_op = ALUOP_W'(5'b01001); end
          FUNC_W'(5): begin dec_kind = K_ALU; dec_ctl.alu_op = ALUOP_W'(5'b01001); end
          default: dec_kind = K_ILL;
        endcase
      end
      OPC_W'(3): begin
        dec_kind           = K_ALU;
        dec_ctl.mem_to_reg = 2'b10;
        dec_ctl.alu_src    = 1'b1;
        dec_ctl.alu_op     = ALUOP_W'(5'b00001);
      end
      OPC_W'(4): begin
        dec_kind           = K_ALU;
        dec_ctl.mem_to_reg = 2'b10;
        dec_ctl.alu_src    = 1'b1;
        dec_ctl.alu_op     = ALUOP_W'(5'b00101);
        dec_ctl.alu_sel    = 1'b1;
      end
      OPC_W'(5): begin
        dec_kind           = K_LW;
        dec_ctl.reg_dst    = 2'b01;
        dec_ctl.mem_to_reg = 2'b01;
        dec_ctl.alu_src    = 1'b1;
        dec_ctl.alu_op     = ALUOP_W'(5'b10101);
      end
      OPC_W'(6): begin
        dec_kind        = K_SW;
        dec_ctl.alu_src = 1'b1;
        dec_ctl.alu_op  = ALUOP_W'(5'b10101);
      end
      OPC_W'(7), OPC_W'(8), OPC_W'(9): begin
        dec_kind          = K_BR;
        dec_ctl.is_branch = 1'b1;
        dec_ctl.lbl_sel   = 1'b1;
      end
      OPC_W'(10): begin
        dec_kind                = K_BR;
        dec_ctl.is_branch       = 1'b1;
        dec_ctl.branch_addr_sel = 1'b1;
      end
      OPC_W'(11), OPC_W'(13), OPC_W'(14): begin
        dec_kind          = K_BR;
        dec_ctl.is_branch = 1'b1;
      end
      OPC_W'(12): begin
        dec_kind          = K_BL;
        dec_ctl.is_branch = 1'b1;
        dec_ctl.reg_dst   = 2'b10;
      end
      default: dec_kind = K_ILL;
    endcase
  end

  // Sequencer; held controls live in ctl_q and are cleared on every exit to F or H.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_F;
      kind_q   <= K_ALU;
      ctl_q    <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      mem_err  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state_q)
        S_F: if (instr_valid) state_q <= S_D;
        S_D: begin
          if (opcode == HALT_OPC) begin
            halted  <= 1'b1;
            state_q <= S_H;
          end else if (dec_kind == K_ILL) begin
            illegal <= 1'b1;
            halted  <= 1'b1;
            state_q <= S_H;
          end else begin
            ctl_q   <= dec_ctl;
            kind_q  <= dec_kind;
            state_q <= S_E;
          end
        end
        S_E: begin
          case (kind_q)
            K_LW, K_SW: begin
              wait_cnt <= '0;
              state_q  <= S_M;
            end
            K_BR: begin
              ctl_q   <= '0;
              state_q <= S_F;
            end
            default: state_q <= S_W;
          endcase
        end
        // A ready on the last allowed wait cycle still completes normally.
        S_M: begin
          if (mem_ready) begin
            if (kind_q == K_LW) begin
              state_q <= S_W;
            end else begin
              ctl_q   <= '0;
              state_q <= S_F;
            end
          end else if (MEM_TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
            mem_err <= 1'b1;
            halted  <= 1'b1;
            ctl_q   <= '0;
            state_q <= S_H;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_W: begin
          ctl_q   <= '0;
          state_q <= S_F;
        end
        S_H: state_q <= S_H;
        default: state_q <= S_F;
      endcase
    end
  end

  assign ir_write  = (state_q == S_F) && instr_valid;
  assign pc_write  = ((state_q == S_E) && (kind_q == K_BR)) ||
                     ((state_q == S_M) && (kind_q == K_SW) && mem_ready) ||
                     (state_q == S_W);
  assign reg_write = (state_q == S_W);
  assign mem_read  = (state_q == S_M) && (kind_q == K_LW);
  assign mem_write = (state_q == S_M) && (kind_q == K_SW);

  assign reg_dst         = ctl_q.reg_dst;
  assign mem_to_reg      = ctl_q.mem_to_reg;
  assign alu_src         = ctl_q.alu_src;
  assign alu_op          = ctl_q.alu_op;
  assign alu_sel         = ctl_q.alu_sel;
  assign is_branch       = ctl_q.is_branch;
  assign branch_addr_sel = ctl_q.branch_addr_sel;
  assign lbl_sel         = ctl_q.lbl_sel;
  assign state           = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected cycle traces are
// built from the decode table and latency rules, then replayed against the DUT.
module tb_multicycle_control_unit;

  localparam int TO = 15;
  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_BL = 4, K_HALT = 5, K_ILL = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [4:0] func;
  logic       instr_valid, mem_ready;
  logic       ir_write, pc_write, reg_write, mem_read, mem_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       alu_src;
  logic [4:0] alu_op;
  logic       alu_sel, is_branch, branch_addr_sel, lbl_sel;
  logic [2:0] state;
  logic       illegal, mem_err, halted;

  int errors = 0;
  int checks = 0;

  multicycle_control_unit #(
    .OPC_W(6), .FUNC_W(5), .ALUOP_W(5), .HALT_OPC(6'b111111), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func),
    .instr_valid(instr_valid), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
    .alu_sel(alu_sel), .is_branch(is_branch), .branch_addr_sel(branch_addr_sel),
    .lbl_sel(lbl_sel), .state(state), .illegal(illegal), .mem_err(mem_err), .halted(halted)
  );

  always #5 clk = ~clk;

  // One cycle: inputs to drive, expected outputs; ctl bits are
  // {reg_dst, mem_to_reg, alu_src, alu_op, alu_sel, is_branch, branch_addr_sel, lbl_sel}.
  typedef struct packed {
    logic        iv;
    logic        mr;
    logic [5:0]  opc;
    logic [4:0]  fn;
    logic [2:0]  st;
    logic [4:0]  strb;
    logic [13:0] ctl;
    logic [13:0] care;
    logic [2:0]  stat;
  } cyc_t;

  cyc_t q[$];

  function automatic void refDecode(input int opc, input int fn, output int kind,
                                    output logic [13:0] ctl, output logic [13:0] care);
    logic [4:0] shTab [0:5];
    shTab[0] = 5'b01010; shTab[1] = 5'b01000; shTab[2] = 5'b01010;
    shTab[3] = 5'b01000; shTab[4] = 5'b01001; shTab[5] = 5'b01001;
    kind = K_ILL;
    ctl  = '0;
    care = '1;
    if (opc == 63) kind = K_HALT;
    else if (opc == 0 && fn == 0) begin kind = K_ALU; ctl = {2'b00, 2'b10, 1'b0, 5'b00001, 4'b0000}; end
    else if (opc == 0 && fn == 1) begin kind = K_ALU; ctl = {2'b00, 2'b10, 1'b0, 5'b00101, 4'b1000}; end
    else if (opc == 1 && fn == 0) begin kind = K_ALU; ctl = {2'b00, 2'b10, 1'b0, 5'b00010, 4'b0000}; end
    else if (opc == 1 && fn == 1) begin kind = K_ALU; ctl = {2'b00, 2'b10, 1'b0, 5'b00011, 4'b0000}; end
    else if (opc == 2 && fn <= 5) begin
      kind = K_ALU; ctl = {5'b0, shTab[fn], 4'b0000}; care = 14'b00_00_0_11111_1111;
    end
    else if (opc == 3) begin kind = K_ALU; ctl = {4'b0, 1'b1, 5'b00001, 4'b0000}; care = 14'b00_00_1_11111_1111; end
    else if (opc == 4) begin kind = K_ALU; ctl = {4'b0, 1'b1, 5'b00101, 4'b1000}; care = 14'b00_00_1_11111_1111; end
    else if (opc == 5) begin kind = K_LW; ctl = {2'b01, 2'b01, 1'b1, 5'b10101, 4'b0000}; end
    else if (opc == 6) begin kind = K_SW; ctl = {4'b0, 1'b1, 5'b10101, 4'b0000}; end
    else if (opc >= 7 && opc <= 9) begin kind = K_BR; ctl = {10'b0, 4'b0101}; end
    else if (opc == 10) begin kind = K_BR; ctl = {10'b0, 4'b0110}; end
    else if (opc == 11 || opc == 13 || opc == 14) begin kind = K_BR; ctl = {10'b0, 4'b0100}; end
    else if (opc == 12) begin kind = K_BL; ctl = {2'b10, 2'b00, 1'b0, 5'b00000, 4'b0100}; end
  endfunction

  // Idle cycle template: don't-care inputs randomised, outputs all expected low.
  function automatic cyc_t blank(input int st);
    cyc_t c;
    c.iv   = 1'($urandom_range(0, 1));
    c.mr   = 1'($urandom_range(0, 1));
    c.opc  = 6'($urandom);
    c.fn   = 5'($urandom);
    c.st   = 3'(st);
    c.strb = '0;
    c.ctl  = '0;
    c.care = '1;
    c.stat = '0;
    return c;
  endfunction

  // Strobe vector order: {ir_write, pc_write, reg_write, mem_read, mem_write}.
  task automatic addInstr(input int opc, input int fn, input int waits, input int idle);
    cyc_t c;
    int kind;
    logic [13:0] ctl, care;
    logic [4:0] mstrb;
    refDecode(opc, fn, kind, ctl, care);
    for (int i = 0; i < idle; i++) begin c = blank(0); c.iv = 1'b0; q.push_back(c); end
    c = blank(0); c.iv = 1'b1; c.strb = 5'b10000; q.push_back(c);
    c = blank(1); c.opc = 6'(opc); c.fn = 5'(fn); q.push_back(c);
    if (kind == K_HALT || kind == K_ILL) begin
      for (int i = 0; i < 4; i++) begin
        c = blank(5); c.iv = 1'b1; c.stat = (kind == K_ILL) ? 3'b101 : 3'b001; q.push_back(c);
      end
      return;
    end
    c = blank(2); c.ctl = ctl; c.care = care;
    if (kind == K_BR) c.strb = 5'b01000;
    q.push_back(c);
    if (kind == K_BR) return;
    if (kind == K_LW || kind == K_SW) begin
      mstrb = (kind == K_LW) ? 5'b00010 : 5'b00001;
      for (int i = 0; i < waits && i < TO; i++) begin
        c = blank(3); c.mr = 1'b0; c.ctl = ctl; c.care = care; c.strb = mstrb; q.push_back(c);
      end
      if (waits >= TO) begin
        for (int i = 0; i < 4; i++) begin
          c = blank(5); c.iv = 1'b1; c.stat = 3'b011; q.push_back(c);
        end
        return;
      end
      c = blank(3); c.mr = 1'b1; c.ctl = ctl; c.care = care;
      c.strb = mstrb | ((kind == K_SW) ? 5'b01000 : 5'b00000);
      q.push_back(c);
      if (kind == K_SW) return;
    end
    c = blank(4); c.ctl = ctl; c.care = care; c.strb = 5'b01100; q.push_back(c);
  endtask

  task automatic checkOutput(input cyc_t c, input int idx);
    logic [4:0]  strb;
    logic [13:0] ctl;
    logic [2:0]  stat;
    strb = {ir_write, pc_write, reg_write, mem_read, mem_write};
    ctl  = {reg_dst, mem_to_reg, alu_src, alu_op, alu_sel, is_branch, branch_addr_sel, lbl_sel};
    stat = {illegal, mem_err, halted};
    checks++;
    assert (state === c.st) else begin
      errors++; $error("[TB] FAIL state step %0d: got %0d want %0d", idx, state, c.st);
    end
    checks++;
    assert (strb === c.strb) else begin
      errors++; $error("[TB] FAIL strobes step %0d: got %b want %b", idx, strb, c.strb);
    end
    checks++;
    assert ((ctl & c.care) === (c.ctl & c.care)) else begin
      errors++; $error("[TB] FAIL controls step %0d: got %b want %b (care %b)", idx, ctl, c.ctl, c.care);
    end
    checks++;
    assert (stat === c.stat) else begin
      errors++; $error("[TB] FAIL status step %0d: got %b want %b", idx, stat, c.stat);
    end
  endtask

  task automatic applyStimulus(input int maxSteps);
    cyc_t c;
    int idx = 0;
    while (q.size() > 0 && idx < maxSteps) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      instr_valid = c.iv;
      mem_ready   = c.mr;
      opcode      = c.opc;
      func        = c.fn;
      @(negedge clk);
      checkOutput(c, idx);
      idx++;
    end
    q.delete();
  endtask

  // Asserts reset just after an edge, checks the cleared outputs, releases mid-cycle.
  task automatic doReset();
    cyc_t z;
    z = '0;
    z.care = '1;
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    #2;
    checkOutput(z, -1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int opc, fn;
    rst_n = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; opcode = '0; func = '0;
    repeat (2) @(posedge clk);
    doReset();

    $display("[TB] directed add, lw, br, bl, ready-on-last-wait sw");
    addInstr(0, 0, 0, 0);
    addInstr(5, 0, 3, 1);
    addInstr(10, 0, 0, 0);
    addInstr(12, 0, 0, 0);
    addInstr(6, 0, TO - 1, 0);
    addInstr(5, 0, TO - 1, 2);
    applyStimulus(100000);

    $display("[TB] randomized instruction stream");
    for (int k = 0; k < 40; k++) begin
      opc = $urandom_range(0, 14);
      if (opc <= 1)      fn = $urandom_range(0, 1);
      else if (opc == 2) fn = $urandom_range(0, 5);
      else               fn = $urandom_range(0, 31);
      addInstr(opc, fn, $urandom_range(0, 6), $urandom_range(0, 2));
    end
    applyStimulus(100000);

    $display("[TB] memory timeout");
    addInstr(6, 0, TO, 0);
    applyStimulus(100000);
    doReset();

    $display("[TB] illegal decodes and halt");
    addInstr(2, 7, 0, 0);
    applyStimulus(100000);
    doReset();
    addInstr(15, 0, 0, 1);
    applyStimulus(100000);
    doReset();
    addInstr(0, 3, 0, 0);
    applyStimulus(100000);
    doReset();
    addInstr(63, 0, 0, 0);
    applyStimulus(100000);
    doReset();

    $display("[TB] reset during sw memory wait");
    addInstr(6, 0, 20, 0);
    applyStimulus(5);
    doReset();
    addInstr(1, 1, 0, 0);
    addInstr(5, 0, 2, 0);
    applyStimulus(100000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
